sprite_plot_scheduler: RTL and testbench

- Parametrised successor to the single-enemy plot path.
- Accepts position-update and kill requests from NUM_SPRITES sprite channels (enemy, player, projectiles).
- Serialises them round-robin onto the single shared VGA plotter: erases each sprite's previous position, then draws the new one.
- Sits between the per-sprite datapaths and the plotter/VGA adapter.

---
 rtl/sprite_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/sprite_plot_scheduler.sv | 171 +++++++++++++++++
 tb/tb_sprite_plot_scheduler.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite plot path: FSM encoding,
// default screen bounds and plotter colour-select values.
package sprite_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PICK,
    S_ERASE_ISSUE,
    S_ERASE_WAIT,
    S_DRAW_ISSUE,
    S_DRAW_WAIT,
    S_DONE
  } state_e;

  localparam int SCREEN_W     = 160;
  localparam int SCREEN_H     = 120;
  localparam int SCREEN_X_MAX = SCREEN_W - 1;
  localparam int SCREEN_Y_MAX = SCREEN_H - 1;

  localparam logic COLOUR_SPRITE = 1'b0;
  localparam logic COLOUR_BG     = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request at or after ptr_i, wrapping.
// Purely combinational so any plotter client can register around it.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  always_comb begin
    int c;
    c       = 0;
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      c = (int'(ptr_i) + k) % N;
      if (!valid_o && req_i[c]) begin
        valid_o    = 1'b1;
        grant_o[c] = 1'b1;
        idx_o      = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/sprite_plot_scheduler.sv
// Serialises per-sprite move/kill requests onto the shared plotter:
// optional erase of the previous position, then draw of the new one.
module sprite_plot_scheduler
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 4,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int X_MAX       = SCREEN_X_MAX,
  parameter int Y_MAX       = SCREEN_Y_MAX,
  parameter int ERASE_EN    = 1,
  parameter int IDX_W       = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic [NUM_SPRITES-1:0]     req,
  input  logic [NUM_SPRITES-1:0]     kill,
  input  logic [NUM_SPRITES*X_W-1:0] req_x,
  input  logic [NUM_SPRITES*Y_W-1:0] req_y,
  input  logic                       plot_done,
  output logic                       start_plot,
  output logic [X_W-1:0]             x_out,
  output logic [Y_W-1:0]             y_out,
  output logic                       erase,
  output logic [IDX_W-1:0]           sprite_id,
  output logic [NUM_SPRITES-1:0]     served,
  output logic                       busy
);

  localparam int N = NUM_SPRITES;

  state_e           state_q, state_d;
  logic [N-1:0]     pend_q, pend_d, kpend_q, kpend_d, lv_q;
  logic [X_W-1:0]   new_x_q [N];
  logic [Y_W-1:0]   new_y_q [N];
  logic [X_W-1:0]   last_x_q [N];
  logic [Y_W-1:0]   last_y_q [N];
  logic [X_W-1:0]   cx [N];
  logic [Y_W-1:0]   cy [N];
  logic [IDX_W-1:0] ptr_q, id_q, gidx;
  logic [N-1:0]     gnt;
  logic             gvalid;
  logic             kill_q;
  logic [X_W-1:0]   sn_x_q, sl_x_q;
  logic [Y_W-1:0]   sn_y_q, sl_y_q;

  rr_arbiter #(.N(N), .IDX_W(IDX_W)) u_arb (
    .req_i   (pend_q | kpend_q),
    .ptr_i   (ptr_q),
    .grant_o (gnt),
    .idx_o   (gidx),
    .valid_o (gvalid)
  );

  always_comb begin
    for (int i = 0; i < N; i++) begin
      cx[i] = (req_x[i*X_W +: X_W] > X_W'(X_MAX)) ? X_W'(X_MAX) : req_x[i*X_W +: X_W];
      cy[i] = (req_y[i*Y_W +: Y_W] > Y_W'(Y_MAX)) ? Y_W'(Y_MAX) : req_y[i*Y_W +: Y_W];
    end
  end

  // Picked channel is cleared first so a same-cycle capture re-arms it.
  always_comb begin
    pend_d  = pend_q;
    kpend_d = kpend_q;
    if (state_q == S_PICK && gvalid) begin
      pend_d  = pend_d & ~gnt;
      kpend_d = kpend_d & ~gnt;
    end
    pend_d  = (pend_d | req) & ~kill;
    kpend_d = kpend_d | kill;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:        if (enable && |(pend_q | kpend_q)) state_d = S_PICK;
      S_PICK: begin
        if (ERASE_EN != 0 && lv_q[gidx]) state_d = S_ERASE_ISSUE;
        else if (kpend_q[gidx])          state_d = S_DONE;
        else                             state_d = S_DRAW_ISSUE;
      end
      S_ERASE_ISSUE: state_d = S_ERASE_WAIT;
      S_ERASE_WAIT:  if (plot_done) state_d = kill_q ? S_DONE : S_DRAW_ISSUE;
      S_DRAW_ISSUE:  state_d = S_DRAW_WAIT;
      S_DRAW_WAIT:   if (plot_done) state_d = S_DONE;
      S_DONE:        state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

  always_comb begin
    start_plot = (state_q == S_ERASE_ISSUE) || (state_q == S_DRAW_ISSUE);
    erase      = COLOUR_SPRITE;
    x_out      = '0;
    y_out      = '0;
    served     = '0;
    case (state_q)
      S_ERASE_ISSUE, S_ERASE_WAIT: begin
        erase = COLOUR_BG;
        x_out = sl_x_q;
        y_out = sl_y_q;
      end
      S_DRAW_ISSUE, S_DRAW_WAIT: begin
        x_out = sn_x_q;
        y_out = sn_y_q;
      end
      S_DONE:  served[id_q] = 1'b1;
      default: ;
    endcase
  end

  assign sprite_id = id_q;
  assign busy      = (state_q != S_IDLE);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      kpend_q <= '0;
      lv_q    <= '0;
      ptr_q   <= '0;
      id_q    <= '0;
      kill_q  <= 1'b0;
      sn_x_q  <= '0;
      sn_y_q  <= '0;
      sl_x_q  <= '0;
      sl_y_q  <= '0;
      for (int i = 0; i < N; i++) begin
        new_x_q[i]  <= '0;
        new_y_q[i]  <= '0;
        last_x_q[i] <= '0;
        last_y_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      kpend_q <= kpend_d;
      for (int i = 0; i < N; i++) begin
        if (req[i] && !kill[i]) begin
          new_x_q[i] <= cx[i];
          new_y_q[i] <= cy[i];
        end
      end
      case (state_q)
        S_PICK: begin
          id_q   <= gidx;
          kill_q <= kpend_q[gidx];
          sn_x_q <= new_x_q[gidx];
          sn_y_q <= new_y_q[gidx];
          sl_x_q <= last_x_q[gidx];
          sl_y_q <= last_y_q[gidx];
        end
        S_DRAW_WAIT: begin
          if (plot_done) begin
            last_x_q[id_q] <= sn_x_q;
            last_y_q[id_q] <= sn_y_q;
            lv_q[id_q]     <= 1'b1;
          end
        end
        S_DONE: begin
          if (kill_q) lv_q[id_q] <= 1'b0;
          ptr_q <= (int'(id_q) == N - 1) ? '0 : id_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_plot_scheduler.sv
// Directed bench for sprite_plot_scheduler with a transaction-level
// model of the pending set, round-robin order and per-sprite history.
module tb_sprite_plot_scheduler;

  localparam int N  = 4;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int XM = 159;
  localparam int YM = 119;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            enable = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    kill = '0;
  logic [N*XW-1:0] req_x = '0;
  logic [N*YW-1:0] req_y = '0;
  logic            plot_done = 1'b0;
  logic            start_plot, erase, busy;
  logic [XW-1:0]   x_out;
  logic [YW-1:0]   y_out;
  logic [1:0]      sprite_id;
  logic [N-1:0]    served;

  always #5 clock = ~clock;

  sprite_plot_scheduler dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .req        (req),
    .kill       (kill),
    .req_x      (req_x),
    .req_y      (req_y),
    .plot_done  (plot_done),
    .start_plot (start_plot),
    .x_out      (x_out),
    .y_out      (y_out),
    .erase      (erase),
    .sprite_id  (sprite_id),
    .served     (served),
    .busy       (busy)
  );

  typedef struct {
    bit is_plot;
    bit er;
    int x;
    int y;
    int id;
    int cyc;
  } ev_t;

  int  n_cmp = 0, n_err = 0, cyc = 0;
  ev_t expq[$];
  ev_t plog[$];
  int  slog[$];
  bit  mon_on = 1'b0, hold_done = 1'b0, spur_req = 1'b0;
  int  lat = 1, pd_cnt = 0, hx = 0, hy = 0;

  bit m_pend[N], m_kpend[N], m_lv[N];
  int m_nx[N], m_ny[N], m_lx[N], m_ly[N], m_ptr;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(string name, string what);
    n_cmp++;
    n_err++;
    $display("FAIL %s: %s", name, what);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 0; m_kpend[i] = 0; m_lv[i] = 0;
      m_nx[i] = 0; m_ny[i] = 0; m_lx[i] = 0; m_ly[i] = 0;
    end
    m_ptr = 0;
    expq.delete();
  endfunction

  function automatic void push_ev(bit p, bit er, int x, int y, int id);
    ev_t e;
    e.is_plot = p; e.er = er; e.x = x; e.y = y; e.id = id; e.cyc = 0;
    expq.push_back(e);
  endfunction

  // Next transaction per the rules: first pending channel from the pointer,
  // erase old spot if known, draw unless killed, then a served pulse.
  function automatic void begin_txn();
    int sel, c;
    bit k;
    sel = -1;
    for (int j = 0; j < N; j++) begin
      c = (m_ptr + j) % N;
      if (sel < 0 && (m_pend[c] || m_kpend[c])) sel = c;
    end
    if (sel < 0) return;
    k = m_kpend[sel];
    m_pend[sel] = 0;
    m_kpend[sel] = 0;
    if (m_lv[sel]) push_ev(1, 1, m_lx[sel], m_ly[sel], sel);
    if (!k) begin
      push_ev(1, 0, m_nx[sel], m_ny[sel], sel);
      m_lx[sel] = m_nx[sel];
      m_ly[sel] = m_ny[sel];
      m_lv[sel] = 1;
    end else begin
      m_lv[sel] = 0;
    end
    push_ev(0, 0, 0, 0, sel);
    m_ptr = (sel + 1) % N;
  endfunction

  always @(negedge clock) begin : mon
    ev_t e, g;
    if (mon_on) begin
      if (start_plot) begin
        if (expq.size() == 0) begin_txn();
        g.is_plot = 1; g.er = erase; g.x = int'(x_out); g.y = int'(y_out);
        g.id = int'(sprite_id); g.cyc = cyc;
        plog.push_back(g);
        if (expq.size() == 0 || !expq[0].is_plot) fail("mon_plot", "start_plot with no plot expected");
        else begin
          e = expq.pop_front();
          chk("mon_erase", int'(g.er), int'(e.er));
          chk("mon_x", g.x, e.x);
          chk("mon_y", g.y, e.y);
          chk("mon_id", g.id, e.id);
        end
      end
      if (served != '0) begin
        if (expq.size() == 0) begin_txn();
        for (int i = 0; i < N; i++) if (served[i]) slog.push_back(i);
        if (expq.size() == 0 || expq[0].is_plot) fail("mon_served", "served pulse while plots still expected or none pending");
        else begin
          e = expq.pop_front();
          chk("mon_served_mask", int'(served), 1 << e.id);
        end
      end
    end
  end

  // Plotter stand-in: acknowledges each command after lat cycles and
  // checks the coordinates stayed put while it was drawing.
  always @(negedge clock) begin : resp
    plot_done = 1'b0;
    if (spur_req) begin
      plot_done = 1'b1;
      spur_req  = 1'b0;
    end
    if (pd_cnt > 0) begin
      pd_cnt--;
      if (pd_cnt == 0) begin
        plot_done = 1'b1;
        chk("held_x", int'(x_out), hx);
        chk("held_y", int'(y_out), hy);
      end
    end
    if (start_plot && !hold_done) begin
      pd_cnt = lat;
      hx = int'(x_out);
      hy = int'(y_out);
    end
  end

  task automatic stage_req(int ch, int x, int y);
    req[ch] = 1'b1;
    req_x[ch*XW +: XW] = XW'(x);
    req_y[ch*YW +: YW] = YW'(y);
  endtask

  task automatic stage_kill(int ch);
    kill[ch] = 1'b1;
  endtask

  task automatic pulse();
    int x, y;
    for (int i = 0; i < N; i++) begin
      if (kill[i]) begin
        m_kpend[i] = 1; m_pend[i] = 0;
      end else if (req[i]) begin
        x = int'(req_x[i*XW +: XW]);
        y = int'(req_y[i*YW +: YW]);
        m_pend[i] = 1;
        m_nx[i] = (x > XM) ? XM : x;
        m_ny[i] = (y > YM) ? YM : y;
      end
    end
    @(negedge clock);
    req = '0;
    kill = '0;
  endtask

  task automatic wait_idle();
    int quiet, t, pcnt;
    quiet = 0; t = 0;
    while (quiet < 3 && t < 400) begin
      @(negedge clock);
      t++;
      if (busy) quiet = 0; else quiet++;
    end
    if (quiet < 3) fail("idle_timeout", "scheduler stayed busy past cycle budget");
    pcnt = 0;
    for (int i = 0; i < N; i++) if (m_pend[i] || m_kpend[i]) pcnt++;
    chk("model_pending_left", pcnt, 0);
    chk("expected_left", expq.size(), 0);
  endtask

  task automatic clear_logs();
    plog.delete();
    slog.delete();
  endtask

  task automatic chk_plot(string nm, int k, int er, int x, int y, int id);
    if (plog.size() <= k) fail(nm, "plot missing");
    else begin
      chk({nm, "_erase"}, int'(plog[k].er), er);
      chk({nm, "_x"}, plog[k].x, x);
      chk({nm, "_y"}, plog[k].y, y);
      chk({nm, "_id"}, plog[k].id, id);
    end
  endtask

  task automatic chk_served(string nm, int k, int id);
    if (slog.size() <= k) fail(nm, "served pulse missing");
    else chk(nm, slog[k], id);
  endtask

  task automatic chk_outputs_zero(string nm);
    chk({nm, "_start"}, int'(start_plot), 0);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_served"}, int'(served), 0);
    chk({nm, "_x"}, int'(x_out), 0);
    chk({nm, "_y"}, int'(y_out), 0);
    chk({nm, "_erase"}, int'(erase), 0);
    chk({nm, "_id"}, int'(sprite_id), 0);
  endtask

  initial begin
    int t, quiet_starts;
    model_reset();
    repeat (3) @(negedge clock);
    chk_outputs_zero("reset");
    reset_n = 1'b1;
    enable  = 1'b1;
    mon_on  = 1'b1;

    // single move, no history
    clear_logs(); lat = 1;
    stage_req(0, 20, 30); pulse(); wait_idle();
    chk("t1_nplots", plog.size(), 1);
    chk_plot("t1_draw", 0, 0, 20, 30, 0);
    chk_served("t1_served", 0, 0);

    // erase then redraw; 1 cycle from plot_done to the next issue
    clear_logs(); lat = 1;
    stage_req(0, 25, 30); pulse(); wait_idle();
    chk("t2_nplots", plog.size(), 2);
    chk_plot("t2_erase", 0, 1, 20, 30, 0);
    chk_plot("t2_draw", 1, 0, 25, 30, 0);
    if (plog.size() == 2) chk("t2_gap", plog[1].cyc - plog[0].cyc, 2);

    // bring pointer back to 0, then contention 1011
    clear_logs(); lat = 2;
    stage_req(3, 1, 1); pulse(); wait_idle();
    chk_plot("t3_prep", 0, 0, 1, 1, 3);
    clear_logs();
    stage_req(0, 40, 41); stage_req(1, 50, 51); stage_req(3, 60, 61); pulse(); wait_idle();
    chk("t3_nplots", plog.size(), 5);
    chk_served("t3_order0", 0, 0);
    chk_served("t3_order1", 1, 1);
    chk_served("t3_order2", 2, 3);

    // pointer at 2 after serving channel 1; 1001 wraps 3 then 0
    clear_logs(); lat = 3;
    stage_req(1, 2, 2); pulse(); wait_idle();
    chk_plot("t4_erase1", 0, 1, 50, 51, 1);
    clear_logs();
    stage_req(0, 70, 70); stage_req(3, 80, 80); pulse(); wait_idle();
    chk_served("t4_order0", 0, 3);
    chk_served("t4_order1", 1, 0);
    chk_plot("t4_first", 0, 1, 60, 61, 3);

    // clamp
    clear_logs(); lat = 1;
    stage_req(2, 200, 127); pulse(); wait_idle();
    chk("t5_nplots", plog.size(), 1);
    chk_plot("t5_draw", 0, 0, 159, 119, 2);

    // enable low holds off; latest of two reqs wins
    clear_logs(); enable = 1'b0;
    stage_req(1, 5, 5); pulse();
    stage_req(1, 9, 9); pulse();
    repeat (6) @(negedge clock);
    chk("t6_hold_busy", int'(busy), 0);
    chk("t6_hold_plots", plog.size(), 0);
    enable = 1'b1;
    wait_idle();
    chk("t6_nplots", plog.size(), 2);
    chk_plot("t6_erase", 0, 1, 2, 2, 1);
    chk_plot("t6_draw", 1, 0, 9, 9, 1);

    // kill: one erase, then served; next move draws without erase
    clear_logs(); lat = 2;
    stage_kill(1); pulse(); wait_idle();
    chk("t7_nplots", plog.size(), 1);
    chk_plot("t7_erase", 0, 1, 9, 9, 1);
    chk_served("t7_served", 0, 1);
    clear_logs();
    stage_req(1, 30, 31); pulse(); wait_idle();
    chk("t8_nplots", plog.size(), 1);
    chk_plot("t8_draw", 0, 0, 30, 31, 1);

    // req+kill same cycle: kill wins; kill without history plots nothing
    clear_logs(); lat = 1;
    stage_req(2, 10, 10); stage_kill(2); pulse(); wait_idle();
    chk("t9_nplots", plog.size(), 1);
    chk_plot("t9_erase", 0, 1, 159, 119, 2);
    clear_logs();
    stage_kill(2); pulse(); wait_idle();
    chk("t9_nohist_plots", plog.size(), 0);
    chk_served("t9_nohist_served", 0, 2);

    // stray plot_done while idle
    clear_logs();
    spur_req = 1'b1;
    repeat (4) @(negedge clock);
    chk("t10_busy", int'(busy), 0);
    chk("t10_plots", plog.size(), 0);

    // reset during ERASE_WAIT
    clear_logs(); hold_done = 1'b1;
    stage_req(0, 11, 12); pulse();
    t = 0;
    while (!start_plot && t < 30) begin @(negedge clock); t++; end
    if (!start_plot) fail("t11_start", "no erase issued before reset");
    @(negedge clock);
    chk("t11_wait_busy", int'(busy), 1);
    chk("t11_wait_erase", int'(erase), 1);
    mon_on = 1'b0;
    reset_n = 1'b0;
    @(negedge clock);
    chk_outputs_zero("t11_rst");
    @(negedge clock);
    reset_n = 1'b1;
    hold_done = 1'b0;
    model_reset();
    quiet_starts = 0;
    repeat (10) begin
      @(negedge clock);
      if (start_plot) quiet_starts++;
    end
    chk("t11_no_start", quiet_starts, 0);
    chk("t11_busy", int'(busy), 0);
    mon_on = 1'b1;

    // history and pointer cleared by reset
    clear_logs();
    stage_req(0, 3, 4); pulse(); wait_idle();
    chk("t12_nplots", plog.size(), 1);
    chk_plot("t12_draw", 0, 0, 3, 4, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
